// File: rtl/lcd_nibble_responder_pkg.sv
// Shared definitions for the LCD nibble responder.
// Holds the top FSM and strobe phase encodings, the HD44780 4-bit
// initialisation nibbles, the default timing constants (50 MHz clock) and
// small helpers that pick the init nibble and settle time for a step.
package lcd_timing_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PWRUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_SETTLE = 3'd3,
        ST_DONE   = 3'd4
    } lcd_state_e;

    typedef enum logic [1:0] {
        PH_IDLE  = 2'd0,
        PH_SETUP = 2'd1,
        PH_PULSE = 2'd2,
        PH_HOLD  = 2'd3
    } strobe_phase_e;

    localparam logic [3:0] INIT_NIB_WAKE  = 4'h3;
    localparam logic [3:0] INIT_NIB_4BIT  = 4'h2;
    localparam int         INIT_STEPS     = 4;
    localparam logic [1:0] INIT_LAST_STEP = 2'(INIT_STEPS - 1);

    localparam int T_SETUP_DEF = 2;
    localparam int T_PULSE_DEF = 12;
    localparam int T_HOLD_DEF  = 1;
    localparam int T_WAIT_DEF  = 2000;
    localparam int T_PWRUP_DEF = 750000;
    localparam int T_INIT1_DEF = 205000;
    localparam int T_INIT2_DEF = 5000;
    localparam int CNT_W_DEF   = 20;

    // Three wake-up nibbles followed by the switch to 4-bit mode.
    function automatic logic [3:0] init_nibble(input logic [1:0] step);
        return (step == INIT_LAST_STEP) ? INIT_NIB_4BIT : INIT_NIB_WAKE;
    endfunction

    // Settle cycles after the nibble of a given step; user writes use t_wait.
    function automatic int settle_cycles(input logic init_mode, input logic [1:0] step,
                                         input int t_init1, input int t_init2, input int t_wait);
        int cyc;
        cyc = t_wait;
        if (init_mode) begin
            if (step == 2'd0) begin
                cyc = t_init1;
            end else if (step == 2'd1) begin
                cyc = t_init2;
            end else begin
                cyc = t_wait;
            end
        end else begin
            cyc = t_wait;
        end
        return cyc;
    endfunction

endpackage

// File: rtl/lcd_nibble_responder_if.sv
// Writer-side handshake between the nibble writer and the LCD responder.
//   iLCD_data/iLCD_rs : nibble and register select, sampled on accept
//   iLCD_writeEN      : write request level
//   iLCD_reset        : init request level (active high)
//   oLCD_response     : one-cycle completion pulse
//   oLCD_busy         : responder not idle
interface lcd_nibble_responder_if;
    logic [3:0] iLCD_data;
    logic       iLCD_rs;
    logic       iLCD_writeEN;
    logic       iLCD_reset;
    logic       oLCD_response;
    logic       oLCD_busy;

    modport master (output iLCD_data, iLCD_rs, iLCD_writeEN, iLCD_reset,
                    input  oLCD_response, oLCD_busy);
    modport slave  (input  iLCD_data, iLCD_rs, iLCD_writeEN, iLCD_reset,
                    output oLCD_response, oLCD_busy);
endinterface

// File: rtl/lcd_strobe_gen.sv
// Generates one LCD enable strobe: T_SETUP cycles E=0, T_PULSE cycles E=1,
// T_HOLD cycles E=0, with D/RS latched on start and held until the next start.
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_start        : begin a strobe, latching i_d/i_rs
//   i_clr          : force the held D/RS to zero (power-up wait)
//   o_e, o_d, o_rs : registered LCD pins
//   o_done         : high during the last hold cycle
module lcd_strobe_gen
    import lcd_timing_pkg::*;
#(
    parameter int T_SETUP = T_SETUP_DEF,
    parameter int T_PULSE = T_PULSE_DEF,
    parameter int T_HOLD  = T_HOLD_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic       i_clr,
    input  logic [3:0] i_d,
    input  logic       i_rs,
    output logic       o_e,
    output logic [3:0] o_d,
    output logic       o_rs,
    output logic       o_done
);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    strobe_phase_e    r_phase, w_phase_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_e, w_e_nxt;
    logic [3:0]       r_d, w_d_nxt;
    logic             r_rs, w_rs_nxt;

    // Phase, counter and pin registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_phase <= PH_IDLE;
            r_cnt   <= CNT_ZERO;
            r_e     <= 1'b0;
            r_d     <= 4'h0;
            r_rs    <= 1'b0;
        end else begin
            r_phase <= w_phase_nxt;
            r_cnt   <= w_cnt_nxt;
            r_e     <= w_e_nxt;
            r_d     <= w_d_nxt;
            r_rs    <= w_rs_nxt;
        end
    end

    // Next phase: each phase counts down from its length minus one.
    always_comb begin
        w_phase_nxt = r_phase;
        w_cnt_nxt   = r_cnt;
        if (i_start) begin
            w_phase_nxt = PH_SETUP;
            w_cnt_nxt   = CNT_W'(T_SETUP - 1);
        end else begin
            case (r_phase)
                PH_IDLE: begin
                    w_cnt_nxt = CNT_ZERO;
                end
                PH_SETUP: begin
                    if (r_cnt == CNT_ZERO) begin
                        w_phase_nxt = PH_PULSE;
                        w_cnt_nxt   = CNT_W'(T_PULSE - 1);
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_ONE;
                    end
                end
                PH_PULSE: begin
                    if (r_cnt == CNT_ZERO) begin
                        w_phase_nxt = PH_HOLD;
                        w_cnt_nxt   = CNT_W'(T_HOLD - 1);
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_ONE;
                    end
                end
                PH_HOLD: begin
                    if (r_cnt == CNT_ZERO) begin
                        w_phase_nxt = PH_IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_ONE;
                    end
                end
                default: begin
                    w_phase_nxt = PH_IDLE;
                    w_cnt_nxt   = CNT_ZERO;
                end
            endcase
        end
    end

    // Next pin values; E follows the next phase so it is a clean register.
    always_comb begin
        w_e_nxt  = (w_phase_nxt == PH_PULSE);
        w_d_nxt  = r_d;
        w_rs_nxt = r_rs;
        if (i_start) begin
            w_d_nxt  = i_d;
            w_rs_nxt = i_rs;
        end else if (i_clr) begin
            w_d_nxt  = 4'h0;
            w_rs_nxt = 1'b0;
        end else begin
            w_d_nxt  = r_d;
            w_rs_nxt = r_rs;
        end
    end

    assign o_e    = r_e;
    assign o_d    = r_d;
    assign o_rs   = r_rs;
    assign o_done = (r_phase == PH_HOLD) && (r_cnt == CNT_ZERO);

endmodule

// File: rtl/lcd_nibble_responder.sv
// LCD-side responder: accepts one nibble per handshake, strobes it onto an
// HD44780 4-bit bus with setup/pulse/hold timing, waits the settle time and
// returns a one-cycle response. An init request runs the 4-bit power-on
// sequence (wait, 0x3, 0x3, 0x3, 0x2).
//   Clock, Reset          : clock, synchronous active-low reset
//   lcd_bus (slave)       : writer handshake (data, rs, writeEN, reset, response, busy)
//   oLCD_E/RS/RW/D        : LCD pins, RW tied low
module lcd_nibble_responder
    import lcd_timing_pkg::*;
#(
    parameter int T_SETUP = T_SETUP_DEF,
    parameter int T_PULSE = T_PULSE_DEF,
    parameter int T_HOLD  = T_HOLD_DEF,
    parameter int T_WAIT  = T_WAIT_DEF,
    parameter int T_PWRUP = T_PWRUP_DEF,
    parameter int T_INIT1 = T_INIT1_DEF,
    parameter int T_INIT2 = T_INIT2_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic                   Clock,
    input  logic                   Reset,
    lcd_nibble_responder_if.slave  lcd_bus,
    output logic                   oLCD_E,
    output logic                   oLCD_RS,
    output logic                   oLCD_RW,
    output logic [3:0]             oLCD_D
);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    lcd_state_e       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_timer;
    logic [1:0]       r_init_step;
    logic             r_init_mode;
    logic             r_armed;
    logic             r_response, w_response_nxt;
    logic             r_busy, w_busy_nxt;
    logic             w_accept, w_timer_zero, w_strobe_done;
    logic             w_start, w_clr, w_rs;
    logic [3:0]       w_nib;
    logic [CNT_W-1:0] w_settle_load;

    // Init requests win over writes; armed blocks re-acceptance of a held level.
    assign w_accept      = (r_state == ST_IDLE) && !lcd_bus.iLCD_reset &&
                           lcd_bus.iLCD_writeEN && r_armed;
    assign w_timer_zero  = (r_timer == CNT_ZERO);
    assign w_settle_load = CNT_W'(settle_cycles(r_init_mode, r_init_step,
                                                T_INIT1, T_INIT2, T_WAIT) - 1);

    // State register.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (lcd_bus.iLCD_reset) begin
                    w_state_nxt = ST_PWRUP;
                end else if (w_accept) begin
                    w_state_nxt = ST_STROBE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_PWRUP: begin
                w_state_nxt = w_timer_zero ? ST_STROBE : ST_PWRUP;
            end
            ST_STROBE: begin
                w_state_nxt = w_strobe_done ? ST_SETTLE : ST_STROBE;
            end
            ST_SETTLE: begin
                if (!w_timer_zero) begin
                    w_state_nxt = ST_SETTLE;
                end else if (r_init_mode && (r_init_step != INIT_LAST_STEP)) begin
                    w_state_nxt = ST_STROBE;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Timer, init bookkeeping and write re-arm.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_timer     <= CNT_ZERO;
            r_init_step <= 2'd0;
            r_init_mode <= 1'b0;
            r_armed     <= 1'b1;
        end else begin
            if (w_accept) begin
                r_armed <= 1'b0;
            end else if (!lcd_bus.iLCD_writeEN) begin
                r_armed <= 1'b1;
            end else begin
                r_armed <= r_armed;
            end
            case (r_state)
                ST_IDLE: begin
                    if (lcd_bus.iLCD_reset) begin
                        r_init_mode <= 1'b1;
                        r_init_step <= 2'd0;
                        r_timer     <= CNT_W'(T_PWRUP - 1);
                    end else if (w_accept) begin
                        r_init_mode <= 1'b0;
                        r_init_step <= 2'd0;
                    end else begin
                        r_init_mode <= r_init_mode;
                    end
                end
                ST_PWRUP: begin
                    if (!w_timer_zero) begin
                        r_timer <= r_timer - CNT_ONE;
                    end else begin
                        r_timer <= r_timer;
                    end
                end
                ST_STROBE: begin
                    if (w_strobe_done) begin
                        r_timer <= w_settle_load;
                    end else begin
                        r_timer <= r_timer;
                    end
                end
                ST_SETTLE: begin
                    if (!w_timer_zero) begin
                        r_timer <= r_timer - CNT_ONE;
                    end else if (r_init_mode && (r_init_step != INIT_LAST_STEP)) begin
                        r_init_step <= r_init_step + 2'd1;
                    end else begin
                        r_timer <= r_timer;
                    end
                end
                ST_DONE: begin
                    r_timer <= r_timer;
                end
                default: begin
                    r_timer <= CNT_ZERO;
                end
            endcase
        end
    end

    // Output decode: strobe control, nibble selection and next handshake outputs.
    always_comb begin
        w_start        = (w_state_nxt == ST_STROBE) && (r_state != ST_STROBE);
        w_clr          = (r_state == ST_IDLE) && (w_state_nxt == ST_PWRUP);
        w_busy_nxt     = (w_state_nxt != ST_IDLE);
        w_response_nxt = (r_state == ST_DONE);
        if (r_state == ST_IDLE) begin
            w_nib = lcd_bus.iLCD_data;
            w_rs  = lcd_bus.iLCD_rs;
        end else if (r_state == ST_PWRUP) begin
            w_nib = init_nibble(2'd0);
            w_rs  = 1'b0;
        end else begin
            // Only used when SETTLE advances to the next init strobe.
            w_nib = init_nibble(r_init_step + 2'd1);
            w_rs  = 1'b0;
        end
    end

    // Registered handshake outputs.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_response <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_response <= w_response_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    lcd_strobe_gen #(
        .T_SETUP (T_SETUP),
        .T_PULSE (T_PULSE),
        .T_HOLD  (T_HOLD),
        .CNT_W   (CNT_W)
    ) u_strobe (
        .i_clk   (Clock),
        .i_rst_n (Reset),
        .i_start (w_start),
        .i_clr   (w_clr),
        .i_d     (w_nib),
        .i_rs    (w_rs),
        .o_e     (oLCD_E),
        .o_d     (oLCD_D),
        .o_rs    (oLCD_RS),
        .o_done  (w_strobe_done)
    );

    assign lcd_bus.oLCD_response = r_response;
    assign lcd_bus.oLCD_busy     = r_busy;
    assign oLCD_RW               = 1'b0;

endmodule
